// File: rtl/bfs_dispatch_sched_pkg.sv
// Shared types, constants and start-node helpers for the BFS dispatch scheduler.
package bfs_dispatch_sched_pkg;

    localparam int         GRID_DIM   = 8;
    localparam int         NUM_CELLS  = GRID_DIM * GRID_DIM;
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [63:0] COST_INIT = {64{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // Row-major cell index {x,y} to the engines' {5'b0,x,5'b0,y} node format.
    function automatic logic [15:0] pack_node(input logic [5:0] idx);
        return {5'b00000, idx[5:3], 5'b00000, idx[2:0]};
    endfunction

    // Returns {well_formed, x, y}; well_formed is low when padding bits are set.
    function automatic logic [6:0] unpack_node(input logic [15:0] node);
        return {((node[15:11] == 5'd0) && (node[7:3] == 5'd0)), node[10:8], node[2:0]};
    endfunction

endpackage

// File: rtl/sched_min_reduce.sv
// Combinational best-of-N select over engine completions: lowest cost, then lowest tag.
module sched_min_reduce #(
    parameter int NUM_ENG = 2,
    parameter int COST_W  = 16
) (
    input  logic [NUM_ENG-1:0]        i_vld,
    input  logic [NUM_ENG-1:0]        i_qual,
    input  logic [NUM_ENG*COST_W-1:0] i_cost,
    input  logic [NUM_ENG*6-1:0]      i_tag,
    output logic                      o_vld,
    output logic [COST_W-1:0]         o_cost,
    output logic [5:0]                o_tag
);
    logic              w_vld;
    logic [COST_W-1:0] w_cost;
    logic [COST_W-1:0] w_c;
    logic [5:0]        w_tag;
    logic [5:0]        w_t;

    // Linear scan keeps the tie-break independent of which engine finished.
    always_comb begin
        w_vld  = 1'b0;
        w_cost = {COST_W{1'b1}};
        w_tag  = 6'd0;
        w_c    = {COST_W{1'b1}};
        w_t    = 6'd0;
        for (int i = 0; i < NUM_ENG; i++) begin
            w_c = i_cost[i*COST_W +: COST_W];
            w_t = i_tag[i*6 +: 6];
            if (i_vld[i] && i_qual[i] &&
                (!w_vld || (w_c < w_cost) || ((w_c == w_cost) && (w_t < w_tag)))) begin
                w_vld  = 1'b1;
                w_cost = w_c;
                w_tag  = w_t;
            end else begin
            end
        end
    end

    assign o_vld  = w_vld;
    assign o_cost = w_cost;
    assign o_tag  = w_tag;

endmodule

// File: rtl/bfs_dispatch_sched.sv
// Sweeps the 8x8 grid, issues every empty cell to a pool of BFS engines and
// reduces their completions to a deterministic minimum-cost placement.
module bfs_dispatch_sched
    import bfs_dispatch_sched_pkg::*;
#(
    parameter int NUM_ENG = 2,
    parameter int COST_W  = 16,
    parameter int REG_W   = 7
) (
    input  logic                      CLK,
    input  logic                      RST_n,
    input  logic                      start,
    input  logic [REG_W-1:0]          reg_num,
    output logic [5:0]                cell_rd_idx,
    input  logic [1:0]                cell_rd_val,
    output logic [15:0]               start_node,
    output logic [NUM_ENG-1:0]        eng_load,
    input  logic [NUM_ENG-1:0]        eng_cost_vld,
    input  logic [NUM_ENG*COST_W-1:0] eng_cost,
    input  logic [NUM_ENG*REG_W-1:0]  eng_reg,
    output logic [2:0]                x_min,
    output logic [2:0]                y_min,
    output logic [COST_W-1:0]         cost_mini,
    output logic                      found,
    output logic                      busy,
    output logic                      output_vld
);
    localparam logic [5:0] LAST_CELL = 6'(NUM_CELLS - 1);

    sched_state_t         r_state;
    sched_state_t         w_state_nxt;
    logic [5:0]           r_ptr;
    logic [5:0]           w_ptr_nxt;
    logic [NUM_ENG-1:0]   r_busy;
    logic [NUM_ENG*6-1:0] r_tag;
    logic [NUM_ENG-1:0]   w_cmp;
    logic [NUM_ENG-1:0]   w_qual;
    logic [NUM_ENG-1:0]   w_free_oh;
    logic [NUM_ENG-1:0]   w_load;
    logic [NUM_ENG-1:0]   w_busy_left;
    logic                 w_adv;
    logic [COST_W-1:0]    r_cost_min;
    logic [2:0]           r_x_min;
    logic [2:0]           r_y_min;
    logic                 r_found;
    logic                 w_best_vld;
    logic [COST_W-1:0]    w_best_cost;
    logic [5:0]           w_best_tag;
    logic                 w_upd;

    // Only engines we believe are busy may complete; stale pulses fall out here.
    assign w_cmp       = eng_cost_vld & r_busy;
    assign w_busy_left = r_busy & ~w_cmp;
    // Lowest clear bit of the registered busy mask: a freed engine waits one cycle.
    assign w_free_oh   = ~r_busy & (r_busy + NUM_ENG'(1'b1));

    // Per-engine region-count qualification.
    always_comb begin
        w_qual = {NUM_ENG{1'b0}};
        for (int i = 0; i < NUM_ENG; i++) begin
            w_qual[i] = (eng_reg[i*REG_W +: REG_W] == reg_num);
        end
    end

    sched_min_reduce #(
        .NUM_ENG (NUM_ENG),
        .COST_W  (COST_W)
    ) u_min_reduce (
        .i_vld  (w_cmp),
        .i_qual (w_qual),
        .i_cost (eng_cost),
        .i_tag  (r_tag),
        .o_vld  (w_best_vld),
        .o_cost (w_best_cost),
        .o_tag  (w_best_tag)
    );

    assign w_upd = w_best_vld &&
                   (!r_found || (w_best_cost < r_cost_min) ||
                    ((w_best_cost == r_cost_min) && (w_best_tag < {r_x_min, r_y_min})));

    // Next-state, scan pointer and issue decision.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_load      = {NUM_ENG{1'b0}};
        w_adv       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SCAN;
                    w_ptr_nxt   = 6'd0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (cell_rd_val != CELL_EMPTY) begin
                    w_adv = 1'b1;
                end else if (|w_free_oh) begin
                    w_adv  = 1'b1;
                    w_load = w_free_oh;
                end else begin
                    w_adv = 1'b0;
                end
                if (w_adv) begin
                    if (r_ptr == LAST_CELL) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_ptr_nxt = r_ptr + 6'd1;
                    end
                end else begin
                    w_ptr_nxt = r_ptr;
                end
            end
            ST_DRAIN: begin
                if (w_busy_left == {NUM_ENG{1'b0}}) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM, scan pointer, engine busy mask and per-engine cell tags.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= 6'd0;
            r_busy  <= {NUM_ENG{1'b0}};
            r_tag   <= {(NUM_ENG*6){1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_busy  <= w_busy_left | w_load;
            for (int i = 0; i < NUM_ENG; i++) begin
                if (w_load[i]) begin
                    r_tag[i*6 +: 6] <= r_ptr;
                end
            end
        end
    end

    // Stored best result; cleared when a sweep starts.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_cost_min <= COST_W'(COST_INIT);
            r_x_min    <= 3'd0;
            r_y_min    <= 3'd0;
            r_found    <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_cost_min <= COST_W'(COST_INIT);
            r_x_min    <= 3'd0;
            r_y_min    <= 3'd0;
            r_found    <= 1'b0;
        end else if (w_upd) begin
            r_cost_min <= w_best_cost;
            r_x_min    <= w_best_tag[5:3];
            r_y_min    <= w_best_tag[2:0];
            r_found    <= 1'b1;
        end else begin
            r_cost_min <= r_cost_min;
            r_x_min    <= r_x_min;
            r_y_min    <= r_y_min;
            r_found    <= r_found;
        end
    end

    assign cell_rd_idx = r_ptr;
    assign start_node  = pack_node(r_ptr);
    assign eng_load    = w_load;
    assign x_min       = r_x_min;
    assign y_min       = r_y_min;
    assign cost_mini   = r_cost_min;
    assign found       = r_found;
    assign busy        = (r_state != ST_IDLE);
    assign output_vld  = (r_state == ST_DONE);

endmodule

// File: tb/tb_bfs_dispatch_sched.sv
// Bench for bfs_dispatch_sched: behavioural engine pool plus a per-sweep
// reference (best qualifying empty cell by cost, then index).
module tb_bfs_dispatch_sched;
    localparam int NUM_ENG = 2;
    localparam int COST_W  = 16;
    localparam int REG_W   = 7;

    logic                      CLK = 1'b0;
    logic                      RST_n;
    logic                      start;
    logic [REG_W-1:0]          reg_num;
    logic [5:0]                cell_rd_idx;
    logic [1:0]                cell_rd_val;
    logic [15:0]               start_node;
    logic [NUM_ENG-1:0]        eng_load;
    logic [NUM_ENG-1:0]        eng_cost_vld;
    logic [NUM_ENG*COST_W-1:0] eng_cost;
    logic [NUM_ENG*REG_W-1:0]  eng_reg;
    logic [2:0]                x_min;
    logic [2:0]                y_min;
    logic [COST_W-1:0]         cost_mini;
    logic                      found;
    logic                      busy;
    logic                      output_vld;

    logic [1:0]        grid     [64];
    logic [COST_W-1:0] cost_tab [64];
    logic [REG_W-1:0]  reg_tab  [64];
    int                lat_tab  [64];
    int                load_cyc [64];
    int                load_eng [64];
    int                cmp_cyc  [64];
    logic [5:0]        exp_cells[$];
    bit                m_busy   [NUM_ENG];
    int                m_cnt    [NUM_ENG];
    logic [5:0]        m_cell   [NUM_ENG];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int loads_seen = 0;
    int last_lat = 0;

    bfs_dispatch_sched #(.NUM_ENG(NUM_ENG), .COST_W(COST_W), .REG_W(REG_W)) dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .start        (start),
        .reg_num      (reg_num),
        .cell_rd_idx  (cell_rd_idx),
        .cell_rd_val  (cell_rd_val),
        .start_node   (start_node),
        .eng_load     (eng_load),
        .eng_cost_vld (eng_cost_vld),
        .eng_cost     (eng_cost),
        .eng_reg      (eng_reg),
        .x_min        (x_min),
        .y_min        (y_min),
        .cost_mini    (cost_mini),
        .found        (found),
        .busy         (busy),
        .output_vld   (output_vld)
    );

    assign cell_rd_val = grid[cell_rd_idx];

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Engine pool: each load starts a countdown; on expiry one completion pulse.
    initial begin : engine_model
        logic [NUM_ENG-1:0] busy0;
        logic [5:0]         e;
        int                 sel;
        int                 lf;
        eng_cost_vld = '0;
        eng_cost     = '0;
        eng_reg      = '0;
        e            = 6'd0;
        for (int i = 0; i < NUM_ENG; i++) begin
            m_busy[i] = 1'b0;
            m_cnt[i]  = 0;
            m_cell[i] = 6'd0;
        end
        forever begin
            @(negedge CLK);
            cyc++;
            for (int i = 0; i < NUM_ENG; i++) busy0[i] = m_busy[i];
            if (|eng_load) begin
                chk("load_onehot", $countones(eng_load), 1);
                sel = 0;
                for (int i = NUM_ENG - 1; i >= 0; i--) if (eng_load[i]) sel = i;
                lf = -1;
                for (int i = NUM_ENG - 1; i >= 0; i--) if (!busy0[i]) lf = i;
                chk("load_lowest_free", sel, lf);
                e = (exp_cells.size() > 0) ? exp_cells.pop_front() : 6'd0;
                chk("start_node", start_node, {5'b00000, e[5:3], 5'b00000, e[2:0]});
            end
            for (int i = 0; i < NUM_ENG; i++) begin
                eng_cost_vld[i] = 1'b0;
                if (m_busy[i]) begin
                    if (m_cnt[i] == 0) begin
                        eng_cost_vld[i]               = 1'b1;
                        eng_cost[i*COST_W +: COST_W]  = cost_tab[m_cell[i]];
                        eng_reg[i*REG_W +: REG_W]     = reg_tab[m_cell[i]];
                        m_busy[i]                     = 1'b0;
                        cmp_cyc[m_cell[i]]            = cyc;
                    end else begin
                        m_cnt[i]--;
                    end
                end
            end
            for (int i = 0; i < NUM_ENG; i++) begin
                if (eng_load[i]) begin
                    m_busy[i]   = 1'b1;
                    m_cnt[i]    = lat_tab[e];
                    m_cell[i]   = e;
                    load_cyc[e] = cyc;
                    load_eng[e] = i;
                    loads_seen++;
                end
            end
        end
    end

    task automatic set_all(input logic [1:0] v);
        for (int k = 0; k < 64; k++) begin
            grid[k]     = v;
            cost_tab[k] = '0;
            reg_tab[k]  = '0;
            lat_tab[k]  = 0;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_x"}, x_min, 0);
        chk({tag, "_y"}, y_min, 0);
        chk({tag, "_cost"}, cost_mini, 16'hFFFF);
        chk({tag, "_found"}, found, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_vld"}, output_vld, 0);
    endtask

    // Reference: best qualifying empty cell, lowest cost then lowest index.
    task automatic run_sweep(input string tag);
        bit                ef;
        logic [5:0]        eidx;
        logic [COST_W-1:0] ec;
        int                n_exp;
        int                lat;
        ef   = 1'b0;
        eidx = 6'd0;
        ec   = 16'hFFFF;
        exp_cells.delete();
        for (int k = 0; k < 64; k++) begin
            if (grid[k] == 2'd0) begin
                exp_cells.push_back(6'(k));
                if ((reg_tab[k] == reg_num) && (!ef || (cost_tab[k] < ec))) begin
                    ef   = 1'b1;
                    ec   = cost_tab[k];
                    eidx = 6'(k);
                end
            end
        end
        n_exp      = exp_cells.size();
        loads_seen = 0;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk({tag, "_busy_scan"}, busy, 1);
        lat = 0;
        while (!output_vld && lat < 3000) begin
            @(negedge CLK);
            lat++;
        end
        last_lat = lat;
        chk({tag, "_vld"}, output_vld, 1);
        chk({tag, "_found"}, found, ef);
        chk({tag, "_cost"}, cost_mini, ec);
        chk({tag, "_x"}, x_min, eidx[5:3]);
        chk({tag, "_y"}, y_min, eidx[2:0]);
        chk({tag, "_loads"}, loads_seen, n_exp);
        @(negedge CLK);
        chk({tag, "_vld_once"}, output_vld, 0);
        chk({tag, "_idle"}, busy, 0);
        repeat (3) @(negedge CLK);
        chk({tag, "_hold_cost"}, cost_mini, ec);
        chk({tag, "_hold_xy"}, {x_min, y_min}, eidx);
    endtask

    initial begin
        int ones;
        RST_n   = 1'b0;
        start   = 1'b0;
        reg_num = '0;
        set_all(2'd1);
        repeat (3) @(negedge CLK);
        check_reset("reset");
        RST_n = 1'b1;
        @(negedge CLK);

        // Two candidates; the cheaper one wins.
        set_all(2'd1);
        grid[9] = 2'd0; grid[45] = 2'd0;
        reg_num = 7'd62;
        cost_tab[9] = 16'd20; cost_tab[45] = 16'd12;
        reg_tab[9] = 7'd62;   reg_tab[45] = 7'd62;
        lat_tab[9] = 5;       lat_tab[45] = 3;
        run_sweep("t1");
        chk("t1_const_xy", {x_min, y_min}, 6'd45);

        // No empty cells: fixed latency, nothing found.
        set_all(2'd1);
        reg_num = 7'd64;
        run_sweep("t2");
        chk("t2_latency", last_lat, 65);

        // Both engines busy: the third cell waits for the first completion.
        set_all(2'd1);
        grid[0] = 2'd0; grid[1] = 2'd0; grid[2] = 2'd0;
        reg_num = 7'd61;
        for (int k = 0; k < 3; k++) begin
            cost_tab[k] = 16'(30 - k);
            reg_tab[k]  = 7'd61;
            lat_tab[k]  = 10;
        end
        run_sweep("t3");
        chk("t3_back_to_back", load_cyc[1] - load_cyc[0], 1);
        chk("t3_issue_after_free", load_cyc[2], cmp_cyc[0] + 1);
        chk("t3_eng_cell1", load_eng[1], 1);
        chk("t3_eng_cell2", load_eng[2], 0);

        // Equal cost, simultaneous and then staggered completions.
        set_all(2'd1);
        grid[3] = 2'd0; grid[17] = 2'd0;
        reg_num = 7'd62;
        cost_tab[3] = 16'd7; cost_tab[17] = 16'd7;
        reg_tab[3] = 7'd62;  reg_tab[17] = 7'd62;
        lat_tab[17] = 2; lat_tab[3] = 16;
        run_sweep("t4a");
        chk("t4a_same_cycle", cmp_cyc[3], cmp_cyc[17]);
        lat_tab[3] = 17;
        run_sweep("t4b");
        chk("t4b_reversed", cmp_cyc[3], cmp_cyc[17] + 1);
        chk("t4b_const_xy", {x_min, y_min}, 6'd3);

        // Cheapest result fails qualification.
        set_all(2'd1);
        grid[10] = 2'd0; grid[20] = 2'd0; grid[30] = 2'd0;
        reg_num = 7'd61;
        cost_tab[10] = 16'd3; cost_tab[20] = 16'd8; cost_tab[30] = 16'd5;
        reg_tab[10] = 7'd60;  reg_tab[20] = 7'd61;  reg_tab[30] = 7'd61;
        lat_tab[10] = 1; lat_tab[20] = 4; lat_tab[30] = 2;
        run_sweep("t5");
        chk("t5_const_cost", cost_mini, 16'd5);

        // Reset during drain, then stale completions must be ignored.
        set_all(2'd1);
        grid[60] = 2'd0; grid[62] = 2'd0;
        reg_num = 7'd62;
        cost_tab[60] = 16'd4; cost_tab[62] = 16'd9;
        reg_tab[60] = 7'd62;  reg_tab[62] = 7'd62;
        lat_tab[60] = 40;     lat_tab[62] = 40;
        exp_cells.delete();
        exp_cells.push_back(6'd60);
        exp_cells.push_back(6'd62);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (70) @(negedge CLK);
        chk("t6_in_drain", busy, 1);
        RST_n = 1'b0;
        @(negedge CLK);
        RST_n = 1'b1;
        check_reset("t6_rst");
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            chk("t6_stale_vld", output_vld, 0);
            chk("t6_stale_busy", busy, 0);
        end
        check_reset("t6_after");
        chk("t6_engines_idle", {m_busy[1], m_busy[0]}, 2'b00);
        set_all(2'd1);
        grid[5] = 2'd0; grid[50] = 2'd0;
        reg_num = 7'd62;
        cost_tab[5] = 16'd11; cost_tab[50] = 16'd6;
        reg_tab[5] = 7'd62;   reg_tab[50] = 7'd62;
        lat_tab[5] = 3;       lat_tab[50] = 5;
        run_sweep("t6_new");

        // Randomized sweeps against the reference.
        for (int t = 0; t < 6; t++) begin
            ones = 0;
            for (int k = 0; k < 64; k++) begin
                case ($urandom_range(0, 3))
                    0:       grid[k] = 2'd0;
                    3:       grid[k] = 2'd2;
                    default: grid[k] = 2'd1;
                endcase
                if (grid[k] == 2'd1) ones++;
            end
            reg_num = 7'(ones);
            for (int k = 0; k < 64; k++) begin
                cost_tab[k] = 16'($urandom_range(1, 12));
                reg_tab[k]  = ($urandom_range(0, 3) == 0) ? 7'(ones - 1) : 7'(ones);
                lat_tab[k]  = $urandom_range(0, 12);
            end
            run_sweep($sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bfs_dispatch_sched.md
Name: bfs_dispatch_sched

Overview:
- Scheduler that sweeps the 8x8 placement grid and dispatches every empty cell as a BFS start node to a pool of NUM_ENG parallel bfs_search engines.
- Collects per-engine costs and reduces them to a deterministic minimum-cost placement.
- Replaces the single-engine, one-start-at-a-time sequencing in the placement top level. It sits between the grid storage and the engine pool.

Parameters:
- NUM_ENG, 2, number of bfs_search engines scheduled (1..4).
- COST_W, 16, cost width.
- REG_W, 7, reached-region count width.

Ports:
- CLK  input  1  clock.
- RST_n  input  1  reset, synchronous, active-low.
- start  input  1  pulse; begins a sweep when idle.
- reg_num  input  REG_W  number of '1' cells in grid; must be stable from start until output_vld.
- cell_rd_idx  output  6  grid read address, row-major x*8+y.
- cell_rd_val  input  2  grid cell value at cell_rd_idx, combinational, same cycle.
- start_node  output  16  {5'b0,x[2:0],5'b0,y[2:0]}; shared by all engines.
- eng_load  output  NUM_ENG  one-hot load pulse to the selected engine.
- eng_cost_vld  input  NUM_ENG  per-engine completion pulse.
- eng_cost  input  NUM_ENG*COST_W  per-engine total cost; engine i at [i*COST_W +: COST_W].
- eng_reg  input  NUM_ENG*REG_W  per-engine reached-region count.
- x_min  output  3  best x.
- y_min  output  3  best y.
- cost_mini  output  COST_W  best cost.
- found  output  1  at least one qualifying result.
- busy  output  1  sweep in progress.
- output_vld  output  1  one-cycle result pulse.

Behaviour:
- Reset (RST_n low at a CLK edge, any state):
  - FSM IDLE; scan ptr 0; all engine busy bits 0; eng_load 0.
  - cost_mini 16'hFFFF; x_min 0; y_min 0; found 0; output_vld 0; busy 0.
  - Mid-sweep reset abandons the sweep; later completions from engines are ignored because their busy bits are clear.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - start=1 -> clear cost_mini/x_min/y_min/found, ptr<=0, go to SCAN next cycle.
  - start in any other state is ignored.
- SCAN (cell_rd_idx = ptr, one cell examined per cycle):
  - cell_rd_val!=0: skip, ptr++.
  - cell_rd_val==0 and a free engine exists:
    - Assert eng_load on the lowest-index free engine and drive start_node from ptr.
    - Set that engine's busy bit and latch its tag (ptr).
    - ptr++.
  - cell_rd_val==0 and no free engine: stall; ptr holds and eng_load stays 0.
  - ptr==63 processed (skipped or issued) -> DRAIN. The 6-bit ptr must not wrap into a second pass.
- Engine freeing:
  - A completion (eng_cost_vld[i]=1 with busy[i]=1) clears busy[i] at that edge.
  - The engine becomes eligible for issue the following cycle, never the same cycle.
  - eng_cost_vld[i] with busy[i]=0 is ignored.
- Result qualification, per completion: eng_reg[i]==reg_num.
- Reduction each cycle:
  - Combinationally select the best qualifying completion: lowest cost, ties broken by lowest tag.
  - Update the stored result if found==0, or cost<cost_mini, or (cost==cost_mini and tag<{x_min,y_min}).
  - The result is therefore independent of NUM_ENG and completion order.
  - found<=1 on any update.
- DRAIN: wait until all busy bits are 0, including completions that arrive in the same cycle -> DONE.
- DONE:
  - output_vld=1 for exactly one cycle, then IDLE.
  - Latency: output_vld is high the cycle after the last completion edge.
- Empty sweep (no candidate cells): output_vld with found=0 and cost_mini=16'hFFFF, 65 cycles after start.
- busy=1 in SCAN, DRAIN and DONE.
- Outputs hold their values after DONE until the next start or reset.

Decomposition:
- Shared package: GRID_DIM=8; CELL_EMPTY=2'b00; COST_INIT all-ones; node pack/unpack functions for the {5'b0,x,5'b0,y} format.
- One sub-module, sched_min_reduce: combinational NUM_ENG-way (cost, tag, qualify) best-select feeding the stored-min compare.

Test Plan:
1. Grid all 1 except cells 9 and 45 empty; engines return cost 20 (cell 9) and 12 (cell 45), eng_reg==reg_num -> output_vld once with x_min=5, y_min=5, cost_mini=12, found=1.
2. Grid all 1 (no empty cells), reg_num=64 -> eng_load never asserted; output_vld 65 cycles after start with found=0, cost_mini=16'hFFFF.
3. NUM_ENG=2, three adjacent empty cells 0,1,2, engines held busy 10 cycles -> cells 0 and 1 issued on consecutive cycles; ptr stalls at 2; cell 2 issued the cycle after the first completion.
4. Two engines complete in the same cycle, both cost 7, tags 3 and 17 -> x_min=0, y_min=3; repeat with completion order reversed over two cycles -> same result.
5. Lowest-cost completion has eng_reg != reg_num -> rejected; next-best qualifying cost is reported.
6. RST_n low for one cycle during DRAIN, then stale eng_cost_vld pulses -> no state change, outputs at reset values; new start completes a normal sweep.
